// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: registered tag/data lookup, whole-line refill over req/ack.
// Optional perf counters are built when ICACHE_PERF_EN is defined.
module icache_dm #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 LINES    = 16,
  parameter int                 WPL      = 4,
  parameter logic [DATA_W-1:0]  NOP_INST = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  input  logic              inv,
  output logic              busy,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);
  localparam int OB = $clog2(WPL);
  localparam int IB = $clog2(LINES);
  localparam int TW = ADDR_W - IB - OB - 2;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e                           state_q, state_d;
  logic [LINES-1:0]                 valid_q, valid_d;
  logic [LINES-1:0][TW-1:0]         tag_q, tag_d;
  logic [LINES*WPL-1:0][DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic [OB-1:0]                    beat_q, beat_d;
  logic                             inv_pend_q, inv_pend_d;
  logic                             flush_pend_q, flush_pend_d;
  logic [DATA_W-1:0]                inst_q, inst_d;
  logic                             inst_valid_q, inst_valid_d;

  logic [OB-1:0] req_off, ref_off;
  logic [IB-1:0] req_idx, ref_idx;
  logic [TW-1:0] req_tag, ref_tag;
  logic          acc, hit;
  logic          unused_bits;

  assign req_off = req_addr[OB+1:2];
  assign req_idx = req_addr[IB+OB+1:OB+2];
  assign req_tag = req_addr[ADDR_W-1:IB+OB+2];
  assign ref_off = addr_q[OB+1:2];
  assign ref_idx = addr_q[IB+OB+1:OB+2];
  assign ref_tag = addr_q[ADDR_W-1:IB+OB+2];
  assign unused_bits = ^{req_addr[1:0], addr_q[1:0]};

  // A same-cycle invalidate makes every line look empty to the lookup.
  assign acc = (state_q == IDLE) && req_valid && !flush;
  assign hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag) && !inv;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    data_d       = data_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    inv_pend_d   = inv_pend_q;
    flush_pend_d = flush_pend_q;
    inst_d       = NOP_INST;
    inst_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (inv) valid_d = '0;
        if (acc) begin
          if (hit) begin
            inst_d       = data_q[{req_idx, req_off}];
            inst_valid_d = 1'b1;
          end else begin
            addr_d           = req_addr;
            beat_d           = '0;
            valid_d[req_idx] = 1'b0;
            inv_pend_d       = 1'b0;
            flush_pend_d     = 1'b0;
            state_d          = REFILL;
          end
        end
      end
      REFILL: begin
        if (inv)   inv_pend_d   = 1'b1;
        if (flush) flush_pend_d = 1'b1;
        if (mem_ack) begin
          data_d[{ref_idx, beat_q}] = mem_rdata;
          beat_d = beat_q + 1'b1;
          // Beats run 0..WPL-1, so the last one is the all-ones offset.
          if (&beat_q) begin
            valid_d[ref_idx] = 1'b1;
            tag_d[ref_idx]   = ref_tag;
            if (inv_pend_q || inv) valid_d = '0;
            if (!(flush_pend_q || flush)) begin
              inst_d       = (ref_off == beat_q) ? mem_rdata : data_q[{ref_idx, ref_off}];
              inst_valid_d = 1'b1;
            end
            inv_pend_d   = 1'b0;
            flush_pend_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      tag_q        <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      beat_q       <= '0;
      inv_pend_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      inv_pend_q   <= inv_pend_d;
      flush_pend_q <= flush_pend_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign busy       = (state_q == REFILL);
  assign mem_req    = (state_q == REFILL);
  assign mem_addr   = (state_q == REFILL) ? {ref_tag, ref_idx, beat_q, 2'b00} : '0;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q  + {31'd0, acc && hit};
    miss_cnt_d = miss_cnt_q + {31'd0, acc && !hit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
